// File: rtl/trap_sequencer_if.sv
// -----------------------------------------------------------------------------
// trap_sequencer_if
//
// Purpose:
//   Groups the commit-stage, interrupt, CSR and pipeline-control signals seen by
//   trap_sequencer into one bundle. The clock and reset are kept outside the
//   interface as plain ports of the sequencer.
//
// Signals (direction given from the sequencer's point of view, modport slave):
//   in   pmode[1:0]          current privilege mode (0 = U, 3 = M)
//   in   mstatus_mie         mstatus.MIE
//   in   mie[XLEN-1:0]       mie CSR
//   in   mtvec[XLEN-1:0]     mtvec CSR
//   in   mepc[XLEN-1:0]      mepc CSR
//   in   trint/swint/exint   timer / software / external interrupt levels
//   in   exc_valid           exception at commit
//   in   exc_code[5:0]       exception cause
//   in   exc_pc[XLEN-1:0]    faulting PC
//   in   mret_valid          mret at commit
//   in   next_pc[XLEN-1:0]   PC of oldest uncommitted instruction
//   in   flush_ack           pipeline drained
//   out  busy                stall commit
//   out  flush_req           request pipeline drain
//   out  trap_valid          one-cycle trap command to the CSR writer
//   out  trap_code[5:0]      cause code
//   out  trap_is_exception   1 = exception, 0 = interrupt
//   out  trap_pc[XLEN-1:0]   value for mepc
//   out  mret_cmd            one-cycle mret command to the CSR writer
//   out  redirect_valid      one-cycle fetch redirect
//   out  redirect_pc         redirect target
//
// Modports:
//   slave  - the trap sequencer itself
//   master - the environment (commit stage, interrupt sources, CSR file)
// -----------------------------------------------------------------------------
interface trap_sequencer_if #(
  parameter int XLEN = 64
);

  logic [1:0]      pmode;
  logic            mstatus_mie;
  logic [XLEN-1:0] mie;
  logic [XLEN-1:0] mtvec;
  logic [XLEN-1:0] mepc;
  logic            trint;
  logic            swint;
  logic            exint;
  logic            exc_valid;
  logic [5:0]      exc_code;
  logic [XLEN-1:0] exc_pc;
  logic            mret_valid;
  logic [XLEN-1:0] next_pc;
  logic            flush_ack;

  logic            busy;
  logic            flush_req;
  logic            trap_valid;
  logic [5:0]      trap_code;
  logic            trap_is_exception;
  logic [XLEN-1:0] trap_pc;
  logic            mret_cmd;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  modport slave (
    input  pmode, mstatus_mie, mie, mtvec, mepc,
    input  trint, swint, exint,
    input  exc_valid, exc_code, exc_pc, mret_valid, next_pc, flush_ack,
    output busy, flush_req,
    output trap_valid, trap_code, trap_is_exception, trap_pc,
    output mret_cmd, redirect_valid, redirect_pc
  );

  modport master (
    output pmode, mstatus_mie, mie, mtvec, mepc,
    output trint, swint, exint,
    output exc_valid, exc_code, exc_pc, mret_valid, next_pc, flush_ack,
    input  busy, flush_req,
    input  trap_valid, trap_code, trap_is_exception, trap_pc,
    input  mret_cmd, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/trap_sequencer.sv
// -----------------------------------------------------------------------------
// trap_sequencer
//
// Purpose:
//   Sequences trap entry and mret for the CSR unit. One event is chosen in IDLE
//   (exception > mret > enabled interrupt; external > software > timer), the
//   pipeline is drained, a single-cycle trap or mret command is issued to the
//   CSR writer, the sequencer waits SETTLE_CYCLES for the CSR update to land
//   and finally emits a single-cycle fetch redirect.
//
// Ports:
//   clk   in  clock
//   rst   in  asynchronous reset, active low (asserted at 0)
//   bus   trap_sequencer_if.slave - all commit / interrupt / CSR / control
//         signals (see rtl/trap_sequencer_if.sv)
//
// Parameters:
//   SETTLE_CYCLES  cycles between the CSR command and the redirect (1..15)
//   XLEN           PC / CSR width; must match the interface's XLEN
//
// Configuration macro:
//   TRAP_VECTORED_EN - when defined, interrupts taken with mtvec[1:0] == 1
//   redirect to (mtvec & ~3) + 4 * cause. When undefined, mtvec[1:0] is
//   ignored and every trap goes to mtvec & ~3.
// -----------------------------------------------------------------------------
module trap_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int          XLEN          = 64
) (
  input  logic             clk,
  input  logic             rst,
  trap_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FLUSH  = 3'd1,
    S_CMD    = 3'd2,
    S_SETTLE = 3'd3,
    S_REDIR  = 3'd4
  } state_e;

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);

  // Interrupt cause for the highest-priority pending line.
  // ip bit order is {external, software, timer}.
  function automatic logic [5:0] int_cause(input logic [2:0] ip);
    logic [5:0] code;
    if (ip[2]) begin
      code = 6'd11;
    end else if (ip[1]) begin
      code = 6'd3;
    end else if (ip[0]) begin
      code = 6'd7;
    end else begin
      code = 6'd0;
    end
    return code;
  endfunction

  state_e          state_q, state_d;
  logic [5:0]      code_q, code_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            is_exc_q, is_exc_d;
  logic            is_mret_q, is_mret_d;
  logic [3:0]      cnt_q, cnt_d;

  logic            busy_q;
  logic            flush_req_q;
  logic            trap_valid_q;
  logic            mret_cmd_q;
  logic            redirect_valid_q;

  logic [2:0]      ip_s;
  logic            ie_s;
  logic            int_take_s;
  logic [XLEN-1:0] base_s;
  logic [XLEN-1:0] tgt_s;
  logic [XLEN-1:0] redirect_pc_s;

  // Pending/enabled interrupt evaluation (only acted upon in IDLE).
  always_comb begin
    ip_s       = {bus.exint & bus.mie[11], bus.swint & bus.mie[3], bus.trint & bus.mie[7]};
    ie_s       = (bus.pmode != 2'd3) | bus.mstatus_mie;
    int_take_s = ie_s & (ip_s != 3'b000);
  end

  // Next-state logic and event latching.
  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    pc_d      = pc_q;
    is_exc_d  = is_exc_q;
    is_mret_d = is_mret_q;
    cnt_d     = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.exc_valid) begin
          state_d   = S_FLUSH;
          code_d    = bus.exc_code;
          pc_d      = bus.exc_pc;
          is_exc_d  = 1'b1;
          is_mret_d = 1'b0;
        end else if (bus.mret_valid) begin
          state_d   = S_FLUSH;
          code_d    = 6'd0;
          pc_d      = {XLEN{1'b0}};
          is_exc_d  = 1'b0;
          is_mret_d = 1'b1;
        end else if (int_take_s) begin
          state_d   = S_FLUSH;
          code_d    = int_cause(ip_s);
          pc_d      = bus.next_pc;
          is_exc_d  = 1'b0;
          is_mret_d = 1'b0;
        end else begin
          state_d   = S_IDLE;
        end
      end
      S_FLUSH: begin
        if (bus.flush_ack) begin
          state_d = S_CMD;
        end else begin
          state_d = S_FLUSH;
        end
      end
      S_CMD: begin
        cnt_d   = SETTLE_LD;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        cnt_d = cnt_q - 4'd1;
        // A counter at 1 reaches 0 this cycle; <= also catches a stray 0.
        if (cnt_q <= 4'd1) begin
          state_d = S_REDIR;
        end else begin
          state_d = S_SETTLE;
        end
      end
      S_REDIR: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, latched event and registered control outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= S_IDLE;
      code_q           <= 6'd0;
      pc_q             <= {XLEN{1'b0}};
      is_exc_q         <= 1'b0;
      is_mret_q        <= 1'b0;
      cnt_q            <= 4'd0;
      busy_q           <= 1'b0;
      flush_req_q      <= 1'b0;
      trap_valid_q     <= 1'b0;
      mret_cmd_q       <= 1'b0;
      redirect_valid_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      code_q           <= code_d;
      pc_q             <= pc_d;
      is_exc_q         <= is_exc_d;
      is_mret_q        <= is_mret_d;
      cnt_q            <= cnt_d;
      // Control flags are registered from the next state so they line up
      // exactly with the state they describe.
      busy_q           <= (state_d != S_IDLE);
      flush_req_q      <= (state_d == S_FLUSH);
      trap_valid_q     <= (state_d == S_CMD) & ~is_mret_d;
      mret_cmd_q       <= (state_d == S_CMD) &  is_mret_d;
      redirect_valid_q <= (state_d == S_REDIR);
    end
  end

  // Redirect target; mtvec and mepc are taken from the REDIR cycle itself so
  // the CSR writes made during the settle window are visible.
  always_comb begin
    base_s = {bus.mtvec[XLEN-1:2], 2'b00};
    tgt_s  = base_s;
`ifdef TRAP_VECTORED_EN
    if (!is_exc_q && !is_mret_q && (bus.mtvec[1:0] == 2'b01)) begin
      tgt_s = base_s + XLEN'({code_q, 2'b00});
    end else begin
      tgt_s = base_s;
    end
`endif
    if (!redirect_valid_q) begin
      redirect_pc_s = {XLEN{1'b0}};
    end else if (is_mret_q) begin
      redirect_pc_s = bus.mepc;
    end else begin
      redirect_pc_s = tgt_s;
    end
  end

  assign bus.busy              = busy_q;
  assign bus.flush_req         = flush_req_q;
  assign bus.trap_valid        = trap_valid_q;
  assign bus.trap_code         = trap_valid_q ? code_q : 6'd0;
  assign bus.trap_is_exception = trap_valid_q & is_exc_q;
  assign bus.trap_pc           = trap_valid_q ? pc_q : {XLEN{1'b0}};
  assign bus.mret_cmd          = mret_cmd_q;
  assign bus.redirect_valid    = redirect_valid_q;
  assign bus.redirect_pc       = redirect_pc_s;

endmodule

// File: tb/tb_trap_sequencer.sv
`timescale 1ns/1ps
module tb_trap_sequencer;

  localparam int XLEN   = 64;
  localparam int SETTLE = 3;

  // kind: 0 = no event, 1 = exception, 2 = interrupt, 3 = mret
  typedef struct {
    logic [1:0]  pmode;
    logic        mstatus_mie;
    logic [63:0] mie;
    logic [63:0] mtvec;
    logic [63:0] mepc;
    logic        trint;
    logic        swint;
    logic        exint;
    logic        exc_valid;
    logic [5:0]  exc_code;
    logic [63:0] exc_pc;
    logic        mret_valid;
    logic [63:0] next_pc;
    int          ack_delay;
    bit          hold;
    int          ekind;
    logic [5:0]  ecode;
    logic [63:0] etpc;
    logic [63:0] erpc;
  } vec_t;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  trap_sequencer_if #(.XLEN(XLEN)) bus ();

  trap_sequencer #(.SETTLE_CYCLES(SETTLE), .XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // busy, flush_req and the three one-cycle pulses {trap, mret, redirect}
  task automatic chk_ctl(input string tag, input logic eb, input logic ef, input logic [2:0] ec);
    chk({tag, " busy"}, 64'(bus.busy), 64'(eb));
    chk({tag, " flush_req"}, 64'(bus.flush_req), 64'(ef));
    chk({tag, " pulses"}, 64'({bus.trap_valid, bus.mret_cmd, bus.redirect_valid}), 64'(ec));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t zv();
    vec_t v;
    v.pmode = 2'd3;        v.mstatus_mie = 1'b0;     v.mie = 64'h0;
    v.mtvec = 64'h80001000; v.mepc = 64'h80000200;
    v.trint = 1'b0; v.swint = 1'b0; v.exint = 1'b0;
    v.exc_valid = 1'b0; v.exc_code = 6'd0; v.exc_pc = 64'h0;
    v.mret_valid = 1'b0; v.next_pc = 64'h80000400;
    v.ack_delay = 0; v.hold = 1'b0;
    v.ekind = 0; v.ecode = 6'd0; v.etpc = 64'h0; v.erpc = 64'h0;
    return v;
  endfunction

  // Reference model: which event the rules select and where it must land.
  function automatic vec_t model(input vec_t v);
    vec_t  r;
    bit    ie;
    logic [63:0] base;
    r  = v;
    ie = (v.pmode != 2'd3) || (v.mstatus_mie == 1'b1);
    r.ekind = 0; r.ecode = 6'd0; r.etpc = 64'h0;
    if (v.exc_valid) begin
      r.ekind = 1; r.ecode = v.exc_code; r.etpc = v.exc_pc;
    end else if (v.mret_valid) begin
      r.ekind = 3;
    end else if (ie && v.exint && v.mie[11]) begin
      r.ekind = 2; r.ecode = 6'd11; r.etpc = v.next_pc;
    end else if (ie && v.swint && v.mie[3]) begin
      r.ekind = 2; r.ecode = 6'd3; r.etpc = v.next_pc;
    end else if (ie && v.trint && v.mie[7]) begin
      r.ekind = 2; r.ecode = 6'd7; r.etpc = v.next_pc;
    end
    base   = v.mtvec & ~64'd3;
    r.erpc = (r.ekind == 3) ? v.mepc : base;
`ifdef TRAP_VECTORED_EN
    if (r.ekind == 2 && v.mtvec[1:0] == 2'b01) r.erpc = base + 64'(r.ecode) * 64'd4;
`endif
    return r;
  endfunction

  // Drives one event in the current IDLE cycle and follows its sequence cycle
  // by cycle; returns in the IDLE cycle after REDIR.
  task automatic run_vec(input vec_t v, input string tag);
    bus.pmode = v.pmode; bus.mstatus_mie = v.mstatus_mie; bus.mie = v.mie;
    bus.mtvec = ~v.mtvec; bus.mepc = v.mepc;
    bus.trint = v.trint; bus.swint = v.swint; bus.exint = v.exint;
    bus.exc_valid = v.exc_valid; bus.exc_code = v.exc_code; bus.exc_pc = v.exc_pc;
    bus.mret_valid = v.mret_valid; bus.next_pc = v.next_pc;
    bus.flush_ack = (v.ack_delay == 0);
    chk({tag, " idle busy"}, 64'(bus.busy), 64'd0);
    tick();
    // Decision edge passed: scramble the event inputs, they must be ignored.
    bus.exc_valid = 1'b0; bus.mret_valid = 1'b0;
    bus.exc_code = 6'($urandom); bus.exc_pc = {$urandom, $urandom};
    bus.next_pc = {$urandom, $urandom};
    if (!v.hold) begin
      bus.trint = 1'b0; bus.swint = 1'b0; bus.exint = 1'b0;
    end
    bus.mtvec = v.mtvec;
    if (v.ekind == 0) begin
      for (int k = 0; k < 2; k++) begin
        chk_ctl({tag, " no-event"}, 1'b0, 1'b0, 3'b000);
        tick();
      end
      return;
    end
    for (int k = 1; k <= v.ack_delay + 1; k++) begin
      bus.flush_ack = (k > v.ack_delay);
      chk_ctl({tag, " flush"}, 1'b1, 1'b1, 3'b000);
      tick();
    end
    bus.flush_ack = 1'($urandom);
    if (v.ekind == 3) begin
      chk_ctl({tag, " mret cmd"}, 1'b1, 1'b0, 3'b010);
    end else begin
      chk_ctl({tag, " trap cmd"}, 1'b1, 1'b0, 3'b100);
      chk({tag, " trap_code"}, 64'(bus.trap_code), 64'(v.ecode));
      chk({tag, " trap_is_exception"}, 64'(bus.trap_is_exception), 64'(v.ekind == 1));
      chk({tag, " trap_pc"}, bus.trap_pc, v.etpc);
    end
    tick();
    for (int s = 1; s <= SETTLE; s++) begin
      chk_ctl({tag, " settle"}, 1'b1, 1'b0, 3'b000);
      tick();
    end
    chk_ctl({tag, " redirect"}, 1'b1, 1'b0, 3'b001);
    chk({tag, " redirect_pc"}, bus.redirect_pc, v.erpc);
    tick();
    chk_ctl({tag, " back to idle"}, 1'b0, 1'b0, 3'b000);
  endtask

  vec_t tbl[$];
  vec_t t;

  initial begin
    // Table of hand-derived vectors.
    t = zv(); t.exc_valid = 1'b1; t.exc_code = 6'd2; t.exc_pc = 64'h80000010;
    t.ekind = 1; t.ecode = 6'd2; t.etpc = 64'h80000010; t.erpc = 64'h80001000; tbl.push_back(t);
    t = zv(); t.exint = 1'b1; t.swint = 1'b1; t.trint = 1'b1; t.mie = 64'h888; t.mstatus_mie = 1'b1;
    t.ekind = 2; t.ecode = 6'd11; t.etpc = 64'h80000400; t.erpc = 64'h80001000; tbl.push_back(t);
    t.mstatus_mie = 1'b0; t.ekind = 0; tbl.push_back(t);
    t.pmode = 2'd0; t.ekind = 2; tbl.push_back(t);
    t = zv(); t.exint = 1'b1; t.swint = 1'b1; t.trint = 1'b1; t.mie = 64'h88; t.pmode = 2'd1;
    t.ekind = 2; t.ecode = 6'd3; t.etpc = 64'h80000400; t.erpc = 64'h80001000; tbl.push_back(t);
    t = zv(); t.exc_valid = 1'b1; t.exc_code = 6'd5; t.exc_pc = 64'h80000020;
    t.trint = 1'b1; t.mie = 64'h80; t.pmode = 2'd0; t.hold = 1'b1;
    t.ekind = 1; t.ecode = 6'd5; t.etpc = 64'h80000020; t.erpc = 64'h80001000; tbl.push_back(t);
    t = zv(); t.trint = 1'b1; t.mie = 64'h80; t.pmode = 2'd0; t.mtvec = 64'h80001001;
    t.ekind = 2; t.ecode = 6'd7; t.etpc = 64'h80000400;
`ifdef TRAP_VECTORED_EN
    t.erpc = 64'h8000101C;
`else
    t.erpc = 64'h80001000;
`endif
    tbl.push_back(t);
    t = zv(); t.exc_valid = 1'b1; t.exc_code = 6'd7; t.exc_pc = 64'h80000030;
    t.trint = 1'b1; t.mie = 64'h80; t.pmode = 2'd0;
    t.ekind = 1; t.ecode = 6'd7; t.etpc = 64'h80000030; t.erpc = 64'h80001000; tbl.push_back(t);
    t = zv(); t.pmode = 2'd0; t.ekind = 0; tbl.push_back(t);
    t = zv(); t.mret_valid = 1'b1; t.ack_delay = 5;
    t.ekind = 3; t.erpc = 64'h80000200; tbl.push_back(t);
    t = zv(); t.mret_valid = 1'b1; t.trint = 1'b1; t.mie = 64'h80; t.pmode = 2'd0; t.mepc = 64'h80000300;
    t.ekind = 3; t.erpc = 64'h80000300; tbl.push_back(t);
    t = zv(); t.exint = 1'b1; t.mie = 64'h800; t.mstatus_mie = 1'b1; t.mtvec = 64'h80001003;
    t.ekind = 2; t.ecode = 6'd11; t.etpc = 64'h80000400; t.erpc = 64'h80001000; tbl.push_back(t);
    t = zv(); t.exc_valid = 1'b1; t.exc_code = 6'd11; t.exc_pc = 64'h80000040; t.mtvec = 64'h80001001;
    t.ekind = 1; t.ecode = 6'd11; t.etpc = 64'h80000040; t.erpc = 64'h80001000; tbl.push_back(t);
    t = zv(); t.swint = 1'b1; t.mie = 64'h8; t.pmode = 2'd0; t.mtvec = 64'h80001001; t.ack_delay = 2;
    t.ekind = 2; t.ecode = 6'd3; t.etpc = 64'h80000400;
`ifdef TRAP_VECTORED_EN
    t.erpc = 64'h8000100C;
`else
    t.erpc = 64'h80001000;
`endif
    tbl.push_back(t);
    t = zv(); t.exint = 1'b1; t.mie = 64'h88; t.mstatus_mie = 1'b1; t.ekind = 0; tbl.push_back(t);

    // Reset state.
    t = zv();
    bus.pmode = t.pmode; bus.mstatus_mie = 1'b0; bus.mie = 64'h0; bus.mtvec = t.mtvec;
    bus.mepc = t.mepc; bus.trint = 1'b0; bus.swint = 1'b0; bus.exint = 1'b0;
    bus.exc_valid = 1'b0; bus.exc_code = 6'd0; bus.exc_pc = 64'h0; bus.mret_valid = 1'b0;
    bus.next_pc = 64'h0; bus.flush_ack = 1'b1;
    rst = 1'b0;
    #1;
    chk_ctl("reset", 1'b0, 1'b0, 3'b000);
    chk("reset redirect_pc", bus.redirect_pc, 64'h0);
    tick(); tick();
    rst = 1'b1;
    tick();
    chk_ctl("after reset", 1'b0, 1'b0, 3'b000);

    foreach (tbl[i]) run_vec(tbl[i], $sformatf("tbl%0d", i));

    // Reset in the middle of SETTLE aborts the sequence.
    t = zv(); t.exc_valid = 1'b1; t.exc_code = 6'd4; t.exc_pc = 64'h80000050;
    bus.exc_valid = 1'b1; bus.exc_code = t.exc_code; bus.exc_pc = t.exc_pc; bus.flush_ack = 1'b1;
    tick();
    bus.exc_valid = 1'b0;
    tick();
    chk_ctl("abort cmd", 1'b1, 1'b0, 3'b100);
    tick();
    chk_ctl("abort settle", 1'b1, 1'b0, 3'b000);
    rst = 1'b0;
    #1;
    chk_ctl("abort reset", 1'b0, 1'b0, 3'b000);
    chk("abort trap_code", 64'(bus.trap_code), 64'd0);
    tick(); tick();
    rst = 1'b1;
    for (int k = 0; k < SETTLE + 4; k++) begin
      tick();
      chk_ctl("post-abort", 1'b0, 1'b0, 3'b000);
    end

    // Randomized sequences against the reference model.
    for (int i = 0; i < 80; i++) begin
      t = zv();
      t.pmode = 2'($urandom_range(0, 3)); t.mstatus_mie = 1'($urandom_range(0, 1));
      t.mie = {$urandom, $urandom};
      t.trint = 1'($urandom_range(0, 1)); t.swint = 1'($urandom_range(0, 1));
      t.exint = 1'($urandom_range(0, 1));
      t.exc_valid = ($urandom_range(0, 3) == 0); t.exc_code = 6'($urandom);
      t.exc_pc = {$urandom, $urandom}; t.mret_valid = ($urandom_range(0, 4) == 0);
      t.next_pc = {$urandom, $urandom}; t.mtvec = {$urandom, $urandom};
      t.mepc = {$urandom, $urandom}; t.ack_delay = $urandom_range(0, 3);
      t = model(t);
      run_vec(t, $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/trap_sequencer.md
Name: trap_sequencer

Overview:
- Sequences trap entry and mret for the CSR unit.
- Arbitrates exception requests from commit and the timer, software and external interrupt lines into a single ordered trap event.
- Drains the pipeline, then issues a one-cycle trap (or mret) command toward the CSR writer. After a configurable settle delay for the CSR update, it emits the PC redirect.
- Sits between the commit stage, the interrupt sources and the CSR file.

Parameters:
- SETTLE_CYCLES, 1: cycles waited after the CSR command before redirect; range 1..15.
- XLEN, 64: width of PC and CSR values.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset (asserted at 0)
- pmode  in  2  current privilege mode (0 = U, 3 = M)
- mstatus_mie  in  1  mstatus.MIE
- mie  in  XLEN  mie CSR
- mtvec  in  XLEN  mtvec CSR
- mepc  in  XLEN  mepc CSR
- trint  in  1  timer interrupt level
- swint  in  1  software interrupt level
- exint  in  1  external interrupt level
- exc_valid  in  1  exception at commit
- exc_code  in  6  exception cause
- exc_pc  in  XLEN  faulting PC
- mret_valid  in  1  mret at commit
- next_pc  in  XLEN  PC of oldest uncommitted instruction
- flush_ack  in  1  pipeline drained
- busy  out  1  stall commit
- flush_req  out  1  request pipeline drain
- trap_valid  out  1  one-cycle trap command to CSR writer
- trap_code  out  6  cause code
- trap_is_exception  out  1  1 = exception, 0 = interrupt
- trap_pc  out  XLEN  value for mepc
- mret_cmd  out  1  one-cycle mret command to CSR writer
- redirect_valid  out  1  one-cycle fetch redirect
- redirect_pc  out  XLEN  redirect target

Behaviour:
- Reset: state IDLE. All outputs 0. Latched cause, pc, kind and settle counter all 0. Reset is honoured in any state and aborts the sequence; no command or redirect is emitted after reset is released.
- Interrupt pending vector: ip = {exint & mie[11], swint & mie[3], trint & mie[7]}.
- Global enable: ie = (pmode != 3) | mstatus_mie.
- Selection in IDLE, in fixed priority order:
  1. exc_valid: exception, code = exc_code, pc = exc_pc.
  2. mret_valid: mret.
  3. ie & ip != 0: interrupt, pc = next_pc. Interrupt priority is external (11) > software (3) > timer (7).
- The selection is latched on the decision edge. Inputs are ignored until the sequence returns to IDLE. Levels deasserting mid-sequence do not cancel the trap.
- States:
  - IDLE: busy = 0. If any event is selected, go to FLUSH and set busy = 1 from the next cycle.
  - FLUSH: flush_req = 1 and busy = 1. Stay until flush_ack = 1, then go to CMD. If flush_ack is already 1 on entry, FLUSH lasts exactly 1 cycle.
  - CMD (1 cycle): for a trap, trap_valid = 1 with the latched trap_code, trap_is_exception and trap_pc. For mret, mret_cmd = 1 instead. Load settle counter = SETTLE_CYCLES. Go to SETTLE.
  - SETTLE: decrement the counter each cycle. When the counter reaches 0, go to REDIR.
  - REDIR (1 cycle): redirect_valid = 1 with redirect_pc computed from the values sampled this cycle:
    - trap: mtvec & ~3
    - mret: mepc
    Go to IDLE; busy drops in the cycle after REDIR.
- Latency: with flush_ack tied to 1, trap_valid appears 2 cycles after the decision edge and redirect_valid appears SETTLE_CYCLES + 1 cycles after trap_valid.
- trap_valid, mret_cmd and redirect_valid are never asserted in the same cycle.
- Back-to-back events: a new event is sampled in the IDLE cycle immediately after REDIR.
- Arithmetic: code is zero-extended by the CSR writer. redirect_pc arithmetic wraps modulo 2^XLEN.

Optional Feature:
- Macro: TRAP_VECTORED_EN.
- Defined: for interrupts with mtvec[1:0] == 1, redirect_pc = (mtvec & ~3) + 4 * code. Exceptions and mode 0 use the base address. mtvec[1:0] >= 2 is treated as direct mode.
- Undefined: mtvec[1:0] is ignored and every trap redirects to mtvec & ~3.

Test Plan:
- Exception: exc_valid = 1, exc_code = 2, exc_pc = 0x80000010, flush_ack = 1, mtvec = 0x80001000, SETTLE_CYCLES = 1 -> trap_valid at +2 with code 2, is_exception = 1, trap_pc 0x80000010; redirect_valid at +4 to 0x80001000.
- Priority: exint = swint = trint = 1, mie bits 11/3/7 set, mstatus_mie = 1, pmode = 3 -> code 11, is_exception = 0, trap_pc = next_pc. Same inputs with mstatus_mie = 0, pmode = 3 -> no trap. Same with pmode = 0 -> trap taken.
- Simultaneous events: exc_valid = 1 together with trint = 1 -> exception taken first. The timer trap follows in a second sequence only if still pending.
- mret: mret_valid = 1, mepc = 0x80000200 -> mret_cmd pulse, then redirect to 0x80000200. trap_valid stays 0.
- Flush wait: flush_ack held 0 for 5 cycles -> flush_req and busy stay 1 and no command is issued. Reset driven low in SETTLE -> all outputs 0 immediately and no redirect after release.
- TRAP_VECTORED_EN defined, mtvec = 0x80001001, timer interrupt -> redirect to 0x8000101C. With the macro undefined -> redirect to 0x80001000.
